ksa_pipe: RTL
=============

Name: ksa_pipe

Overview:
- Parametrised, pipelined Kogge-Stone prefix adder/subtractor. It is the successor to the fixed 8-bit combinational KSA.
- Adds the following over the 8-bit block:
  - configurable width
  - carry-in
  - add/subtract mode
  - signed overflow flag
  - selectable pipeline cuts between prefix levels
  - a valid/ready handshake with backpressure
- Sits in the datapath wherever wide adds must close timing at high clock rates.

Parameters:
- WIDTH, 32: operand width in bits, ≥2 (non-power-of-2 allowed).
- LEVELS, derived as clog2(WIDTH): number of prefix levels. Not user-set.
- REG_MASK, 0: one bit per cut point, LEVELS+1 bits wide.
  - bit 0 = register after the generate/propagate (square) stage.
  - bit k = register after prefix level k.
  - bit LEVELS is ignored; the output register is always present.
- LATENCY, derived as 1 + popcount(REG_MASK[LEVELS-1:0]): cycles from input accept to output valid when there is no stall.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands present.
- in_ready, output, 1: block can accept this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in. Ignored when sub=1.
- sub, input, 1: 0 = A+B+cin; 1 = A−B (computed as A+~B+1).
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts.
- sum, output, WIDTH: result.
- cout, output, 1: carry out of the MSB. In subtract mode, cout=1 means no borrow.
- ovf, output, 1: two's-complement overflow, a[W-1]^b'[W-1] is 0 and sum[W-1]≠a[W-1], where b' is the effective B operand.

Behaviour:
- Reset (async assert, sync deassert by the integrator): all stage valid bits and out_valid clear to 0; sum, cout and ovf clear to 0; in_ready=1 after reset.
- Stage 0 (combinational into the first cut):
  - b' = sub ? ~b : b; c0 = sub ? 1 : cin.
  - g[i] = a&b', p[i] = a^b'.
  - Carry-in is folded in as g[-1]=c0 with p[-1]=0, so bit 0 prefix = g0 | p0&c0.
- Level k (1..LEVELS), distance d = 2^(k-1):
  - for i ≥ d: G = Gi | Pi&G(i-d); P = Pi&P(i-d).
  - for i < d: the node passes through unchanged.
  - The i-d index uses the carry-in–folded prefix.
- Final stage:
  - carries c[i] = G(i-1), with c[0]=c0.
  - sum[i] = p[i]^c[i].
  - cout = G(W-1).
  - ovf = c[W]^c[W-1].
  - Raw p vectors and the a/b' MSBs travel with the pipe.
- Pipeline is a single global-enable pipe: advance = out_ready | ~out_valid. in_ready = advance (combinational).
- On advance, every stage register loads from its predecessor, and each stage's valid bit loads from the previous valid (in_valid at the head).
- When advance is low, all stages hold. No bubble collapse and no data loss.
- A transfer occurs when valid & ready on the same edge, at both the input and the output side.
- Throughput: 1 result per cycle when out_ready stays high.
- Output stability: sum, cout and ovf hold stable while out_valid=1 and out_ready=0.
- Bubbles: cycles with in_valid=0 insert bubbles; data registers may update, but the valid bit carries 0.
- Reset mid-operation: all in-flight operations are discarded immediately; out_valid drops asynchronously.
- REG_MASK=0 gives LATENCY=1 (output register only).
- Wrap-around: sum is modulo 2^WIDTH; no saturation.
- Simultaneous in_valid and out_ready with a full pipe: accept and emit on the same edge.

Decomposition:
- Package ksa_pkg holds:
  - clog2 function
  - popcount function
  - op-mode constants (OP_ADD=0, OP_SUB=1)
  - a struct for a stage payload {g, p, p_raw, a_msb, b_msb, c0}, parametrised by width via a localparam in the module.
- Sub-module ksa_prefix_level (WIDTH, DIST): combinational one-level black-cell/pass-through array. Instantiated LEVELS times in a generate loop. The register cut after each level is selected by REG_MASK.

Test Plan:
1. WIDTH=32, REG_MASK=0, add, a=FFFFFFFF, b=0, cin=1 -> next cycle sum=00000000, cout=1, ovf=0.
2. Sub, a=5, b=7 -> sum=FFFFFFFE, cout=0 (borrow), ovf=0. Sub, a=80000000, b=1 -> sum=7FFFFFFF, cout=1, ovf=1.
3. REG_MASK=0b000101 (LATENCY=3): stream 100 random ops with out_ready=1 -> results in order, exactly 3 cycles after accept, 1 per cycle. Results match the golden model a+b+cin or a−b.
4. Backpressure: fill the pipe, drop out_ready for 5 cycles -> in_ready=0, sum frozen, out_valid=1. Re-assert -> all values emerge in order with no duplicates or losses.
5. Assert rst_n=0 mid-stream with 3 ops in flight -> out_valid=0 immediately, sum=0. After release, the first new op emerges with correct latency and no stale data.
6. WIDTH=13 (non-power-of-2), exhaustive carry chains, a=1FFF, b=0001, cin=0 -> sum=0000, cout=1. a=0FFF, b=0001 -> sum=1000, ovf=1.

Source files
------------

// File: rtl/ksa_pipe_pkg.sv
// Shared helpers and operation constants for the pipelined Kogge-Stone adder.
package ksa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int popcount(input int unsigned value, input int bits);
    int count;
    count = 0;
    for (int i = 0; i < bits; i++) begin
      count = count + int'(value[i]);
    end
    return count;
  endfunction

endpackage

// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for ksa_pipe; master drives operands and out_ready.
interface ksa_pipe_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/ksa_pipe_prefix_level.sv
// One Kogge-Stone prefix level: black cells at distance DIST, pass-through below it.
module ksa_prefix_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_node
    if (i >= DIST) begin : g_black
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      assign p_out[i] = p_in[i] & p_in[i-DIST];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with optional register cuts between prefix
// levels and a single global-enable valid/ready pipe.
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int unsigned REG_MASK = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  ksa_pipe_if.slave bus
);

  localparam int LEVELS = clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p_raw;
    logic             a_msb;
    logic             b_msb;
    logic             c0;
  } stage_t;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_sq;
  logic [WIDTH-1:0] p_sq;
  logic             c0;
  stage_t           head;

  assign advance      = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = advance;

  // Carry-in is folded into bit 0 so every prefix node ends up carrying its true carry.
  always_comb begin
    b_eff      = (bus.sub == OP_ADD) ? bus.b : ~bus.b;
    c0         = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
    g_sq       = bus.a & b_eff;
    p_sq       = bus.a ^ b_eff;
    head.g     = {g_sq[WIDTH-1:1], g_sq[0] | (p_sq[0] & c0)};
    head.p     = {p_sq[WIDTH-1:1], 1'b0};
    head.p_raw = p_sq;
    head.a_msb = bus.a[WIDTH-1];
    head.b_msb = b_eff[WIDTH-1];
    head.c0    = c0;
  end

  for (genvar k = 0; k <= LEVELS; k++) begin : g_stage
    stage_t node;
    stage_t cut;
    logic   node_valid;
    logic   cut_valid;

    if (k == 0) begin : g_head
      assign node       = head;
      assign node_valid = bus.in_valid;
    end else begin : g_level
      stage_t           prev;
      logic [WIDTH-1:0] g_lvl;
      logic [WIDTH-1:0] p_lvl;

      assign prev = g_stage[k-1].cut;

      ksa_prefix_level #(
        .WIDTH (WIDTH),
        .DIST  (1 << (k - 1))
      ) u_level (
        .g_in  (prev.g),
        .p_in  (prev.p),
        .g_out (g_lvl),
        .p_out (p_lvl)
      );

      assign node = '{g: g_lvl, p: p_lvl, p_raw: prev.p_raw,
                      a_msb: prev.a_msb, b_msb: prev.b_msb, c0: prev.c0};
      assign node_valid = g_stage[k-1].cut_valid;
    end

    // The cut after the last level is always the output register, so its mask bit is ignored.
    if (k < LEVELS && REG_MASK[k] == 1'b1) begin : g_cut
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cut       <= '0;
          cut_valid <= 1'b0;
        end else if (advance) begin
          cut       <= node;
          cut_valid <= node_valid;
        end
      end
    end else begin : g_wire
      assign cut       = node;
      assign cut_valid = node_valid;
    end
  end

  logic [WIDTH-1:0] last_g;
  logic [WIDTH-1:0] last_p_raw;
  logic             last_a_msb;
  logic             last_b_msb;
  logic             last_c0;
  logic             last_valid;
  logic             unused_last_p;
  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;

  assign last_g     = g_stage[LEVELS].cut.g;
  assign last_p_raw = g_stage[LEVELS].cut.p_raw;
  assign last_a_msb = g_stage[LEVELS].cut.a_msb;
  assign last_b_msb = g_stage[LEVELS].cut.b_msb;
  assign last_c0    = g_stage[LEVELS].cut.c0;
  assign last_valid = g_stage[LEVELS].cut_valid;

  // Every node has absorbed the carry-in by now, so the final group propagate is all zeros.
  assign unused_last_p = ^g_stage[LEVELS].cut.p;

  always_comb begin
    carries   = {last_g[WIDTH-2:0], last_c0};
    sum_next  = last_p_raw ^ carries;
    cout_next = last_g[WIDTH-1];
    ovf_next  = ~(last_a_msb ^ last_b_msb) & (sum_next[WIDTH-1] ^ last_a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= last_valid;
      bus.sum       <= sum_next;
      bus.cout      <= cout_next;
      bus.ovf       <= ovf_next;
    end
  end

endmodule
